cpl_op_mux_inner: RTL and testbench

Completion-operation multiplexer core for the mqnic interface. It arbitrates completion requests from two source ports (TX/RX completion paths) onto one completion-write request stream using round-robin arbitration. It tags each forwarded request with the source port index, and routes completion-status responses back to the originating port by that tag bit. It sits between the interface's completion producers and the shared completion-queue manager.

---
 rtl/cpl_op_mux_inner_pkg.sv | 16 +
 rtl/cpl_op_mux_inner_rr_arbiter_2.sv | 18 +
 rtl/cpl_op_mux_inner.sv | 110 +++++++++++
 tb/tb_cpl_op_mux_inner.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/cpl_op_mux_inner_pkg.sv
// cpl_op_mux_inner_pkg: shared widths and request record for the completion-op mux
package cpl_op_mux_inner_pkg;
    localparam int PORTS = 2;
    localparam int SELECT_WIDTH = 2;
    localparam int QUEUE_INDEX_WIDTH = 13;
    localparam int S_REQ_TAG_WIDTH = 6;
    localparam int M_REQ_TAG_WIDTH = S_REQ_TAG_WIDTH + 1;
    localparam int CPL_DATA_WIDTH = 256;

    typedef struct packed {
        logic [SELECT_WIDTH-1:0]      sel;
        logic [QUEUE_INDEX_WIDTH-1:0] queue;
        logic [M_REQ_TAG_WIDTH-1:0]   tag;
        logic [CPL_DATA_WIDTH-1:0]    data;
    } req_t;
endpackage

// File: rtl/cpl_op_mux_inner_rr_arbiter_2.sv
// cpl_op_mux_inner_rr_arbiter_2: two-request round-robin arbiter, port 0 favoured after reset
module cpl_op_mux_inner_rr_arbiter_2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       ack,
    output logic [1:0] grant,
    output logic       grant_idx
);
    logic last;

    always_ff @(posedge clk or negedge rst)
        if (!rst) last <= 1'b1;
        else if (ack) last <= grant_idx;

    assign grant_idx = &req ? ~last : req[1];
    assign grant = ~|req ? 2'b00 : grant_idx ? 2'b10 : 2'b01;
endmodule

// File: rtl/cpl_op_mux_inner.sv
// cpl_op_mux_inner: round-robin completion request mux with tag-routed status demux
// Define CPL_OP_MUX_STATUS_REG_EN to register the status demux (1-cycle latency).
module cpl_op_mux_inner
    import cpl_op_mux_inner_pkg::*;
(
    input  logic                                 clk,
    input  logic                                 rst,
    output logic [SELECT_WIDTH-1:0]              m_axis_req_sel,
    output logic [QUEUE_INDEX_WIDTH-1:0]         m_axis_req_queue,
    output logic [M_REQ_TAG_WIDTH-1:0]           m_axis_req_tag,
    output logic [CPL_DATA_WIDTH-1:0]            m_axis_req_data,
    output logic                                 m_axis_req_valid,
    input  logic                                 m_axis_req_ready,
    input  logic [M_REQ_TAG_WIDTH-1:0]           s_axis_req_status_tag,
    input  logic                                 s_axis_req_status_full,
    input  logic                                 s_axis_req_status_error,
    input  logic                                 s_axis_req_status_valid,
    input  logic [PORTS*SELECT_WIDTH-1:0]        s_axis_req_sel,
    input  logic [PORTS*QUEUE_INDEX_WIDTH-1:0]   s_axis_req_queue,
    input  logic [PORTS*S_REQ_TAG_WIDTH-1:0]     s_axis_req_tag,
    input  logic [PORTS*CPL_DATA_WIDTH-1:0]      s_axis_req_data,
    input  logic [PORTS-1:0]                     s_axis_req_valid,
    output logic [PORTS-1:0]                     s_axis_req_ready,
    output logic [PORTS*S_REQ_TAG_WIDTH-1:0]     m_axis_req_status_tag,
    output logic [PORTS-1:0]                     m_axis_req_status_full,
    output logic [PORTS-1:0]                     m_axis_req_status_error,
    output logic [PORTS-1:0]                     m_axis_req_status_valid
);
    logic [PORTS-1:0] grant;
    logic grant_idx, int_ready, accept, m_valid, temp_valid;
    req_t in_req, m_reg, temp_reg;

    cpl_op_mux_inner_rr_arbiter_2 u_arb (
        .clk(clk),
        .rst(rst),
        .req(s_axis_req_valid),
        .ack(accept),
        .grant(grant),
        .grant_idx(grant_idx)
    );

    assign s_axis_req_ready = int_ready ? grant : '0;
    assign accept = |(s_axis_req_valid & s_axis_req_ready);

    always_comb begin
        in_req.sel = grant_idx ? s_axis_req_sel[2*SELECT_WIDTH-1:SELECT_WIDTH] : s_axis_req_sel[SELECT_WIDTH-1:0];
        in_req.queue = grant_idx ? s_axis_req_queue[2*QUEUE_INDEX_WIDTH-1:QUEUE_INDEX_WIDTH] : s_axis_req_queue[QUEUE_INDEX_WIDTH-1:0];
        in_req.tag = {grant_idx, grant_idx ? s_axis_req_tag[2*S_REQ_TAG_WIDTH-1:S_REQ_TAG_WIDTH] : s_axis_req_tag[S_REQ_TAG_WIDTH-1:0]};
        in_req.data = grant_idx ? s_axis_req_data[2*CPL_DATA_WIDTH-1:CPL_DATA_WIDTH] : s_axis_req_data[CPL_DATA_WIDTH-1:0];
    end

    // skid buffer: temp only fills when main is stalled, which also drops int_ready
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            int_ready <= 1'b0;
            m_valid <= 1'b0;
            temp_valid <= 1'b0;
            m_reg <= '0;
            temp_reg <= '0;
        end else begin
            int_ready <= m_axis_req_ready | (~temp_valid & (~m_valid | ~accept));
            if (int_ready) begin
                if (m_axis_req_ready | ~m_valid) begin
                    m_valid <= accept;
                    if (accept) m_reg <= in_req;
                end else begin
                    temp_valid <= accept;
                    if (accept) temp_reg <= in_req;
                end
            end else if (m_axis_req_ready) begin
                m_valid <= temp_valid;
                temp_valid <= 1'b0;
                m_reg <= temp_reg;
            end
        end

    assign m_axis_req_valid = m_valid;
    assign m_axis_req_sel = m_reg.sel;
    assign m_axis_req_queue = m_reg.queue;
    assign m_axis_req_tag = m_reg.tag;
    assign m_axis_req_data = m_reg.data;

    logic [PORTS*S_REQ_TAG_WIDTH-1:0] st_tag;
    logic [PORTS-1:0] st_full, st_err, st_vld;

    assign st_tag = {PORTS{s_axis_req_status_tag[S_REQ_TAG_WIDTH-1:0]}};
    assign st_full = {PORTS{s_axis_req_status_full}};
    assign st_err = {PORTS{s_axis_req_status_error}};
    assign st_vld = ~s_axis_req_status_valid ? 2'b00 : s_axis_req_status_tag[S_REQ_TAG_WIDTH] ? 2'b10 : 2'b01;

`ifdef CPL_OP_MUX_STATUS_REG_EN
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            m_axis_req_status_tag <= '0;
            m_axis_req_status_full <= '0;
            m_axis_req_status_error <= '0;
            m_axis_req_status_valid <= '0;
        end else begin
            m_axis_req_status_tag <= st_tag;
            m_axis_req_status_full <= st_full;
            m_axis_req_status_error <= st_err;
            m_axis_req_status_valid <= st_vld;
        end
`else
    assign m_axis_req_status_tag = st_tag;
    assign m_axis_req_status_full = st_full;
    assign m_axis_req_status_error = st_err;
    assign m_axis_req_status_valid = st_vld;
`endif
endmodule

// File: tb/tb_cpl_op_mux_inner.sv
// tb_cpl_op_mux_inner: directed checks of arbitration, skid buffering, reset and status demux
module tb_cpl_op_mux_inner;
    import cpl_op_mux_inner_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic [1:0] m_axis_req_sel;
    logic [12:0] m_axis_req_queue;
    logic [6:0] m_axis_req_tag;
    logic [255:0] m_axis_req_data;
    logic m_axis_req_valid, m_axis_req_ready;
    logic [6:0] s_axis_req_status_tag;
    logic s_axis_req_status_full, s_axis_req_status_error, s_axis_req_status_valid;
    logic [3:0] s_axis_req_sel;
    logic [25:0] s_axis_req_queue;
    logic [11:0] s_axis_req_tag;
    logic [511:0] s_axis_req_data;
    logic [1:0] s_axis_req_valid, s_axis_req_ready;
    logic [11:0] m_axis_req_status_tag;
    logic [1:0] m_axis_req_status_full, m_axis_req_status_error, m_axis_req_status_valid;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [6:0] tag;
        logic full, err, vld;
        logic [11:0] e_tag;
        logic [1:0] e_full, e_err, e_vld;
    } svec_t;
    svec_t tbl [4];

    always #5 clk = ~clk;

    cpl_op_mux_inner dut (
        .clk(clk),
        .rst(rst),
        .m_axis_req_sel(m_axis_req_sel),
        .m_axis_req_queue(m_axis_req_queue),
        .m_axis_req_tag(m_axis_req_tag),
        .m_axis_req_data(m_axis_req_data),
        .m_axis_req_valid(m_axis_req_valid),
        .m_axis_req_ready(m_axis_req_ready),
        .s_axis_req_status_tag(s_axis_req_status_tag),
        .s_axis_req_status_full(s_axis_req_status_full),
        .s_axis_req_status_error(s_axis_req_status_error),
        .s_axis_req_status_valid(s_axis_req_status_valid),
        .s_axis_req_sel(s_axis_req_sel),
        .s_axis_req_queue(s_axis_req_queue),
        .s_axis_req_tag(s_axis_req_tag),
        .s_axis_req_data(s_axis_req_data),
        .s_axis_req_valid(s_axis_req_valid),
        .s_axis_req_ready(s_axis_req_ready),
        .m_axis_req_status_tag(m_axis_req_status_tag),
        .m_axis_req_status_full(m_axis_req_status_full),
        .m_axis_req_status_error(m_axis_req_status_error),
        .m_axis_req_status_valid(m_axis_req_status_valid)
    );

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_out(input string nm, input logic [6:0] tag);
        chk({nm, "_valid"}, 256'(m_axis_req_valid), 256'(1'b1));
        chk({nm, "_tag"}, 256'(m_axis_req_tag), 256'(tag));
        chk({nm, "_data"}, m_axis_req_data, tag[6] ? 256'hB1 : 256'hA0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish within time limit");
        $fatal(1);
    end

    initial begin
        logic [6:0] seq [4];
        int acc;
        tbl[0] = '{7'h45, 1'b1, 1'b0, 1'b1, 12'h145, 2'b11, 2'b00, 2'b10};
        tbl[1] = '{7'h05, 1'b0, 1'b1, 1'b1, 12'h145, 2'b00, 2'b11, 2'b01};
        tbl[2] = '{7'h7F, 1'b1, 1'b1, 1'b0, 12'hFFF, 2'b11, 2'b11, 2'b00};
        tbl[3] = '{7'h40, 1'b0, 1'b0, 1'b1, 12'h000, 2'b00, 2'b00, 2'b10};
        seq = '{7'h11, 7'h6A, 7'h11, 7'h6A};
        rst = 1'b0;
        m_axis_req_ready = 1'b0;
        s_axis_req_status_tag = '0;
        s_axis_req_status_full = 1'b0;
        s_axis_req_status_error = 1'b0;
        s_axis_req_status_valid = 1'b0;
        s_axis_req_sel = {2'b10, 2'b01};
        s_axis_req_queue = {13'd5, 13'h11};
        s_axis_req_tag = {6'h2A, 6'h11};
        s_axis_req_data = {256'hB1, 256'hA0};
        s_axis_req_valid = 2'b00;
        repeat (2) @(negedge clk);
        chk("rst_valid", 256'(m_axis_req_valid), 256'(1'b0));
        chk("rst_sel", 256'(m_axis_req_sel), 256'(2'b00));
        chk("rst_queue", 256'(m_axis_req_queue), 256'(13'h0));
        chk("rst_tag", 256'(m_axis_req_tag), 256'(7'h0));
        chk("rst_data", m_axis_req_data, 256'h0);
        chk("rst_ready", 256'(s_axis_req_ready), 256'(2'b00));
        chk("rst_st_valid", 256'(m_axis_req_status_valid), 256'(2'b00));
        chk("rst_st_tag", 256'(m_axis_req_status_tag), 256'(12'h0));
        chk("rst_st_full", 256'(m_axis_req_status_full), 256'(2'b00));
        chk("rst_st_err", 256'(m_axis_req_status_error), 256'(2'b00));
        // release with port 0 waiting; ready appears one edge later
        rst = 1'b1;
        s_axis_req_valid = 2'b01;
        m_axis_req_ready = 1'b1;
        #1 chk("ready_pre", 256'(s_axis_req_ready), 256'(2'b00));
        cyc();
        chk("ready_first", 256'(s_axis_req_ready), 256'(2'b01));
        chk("valid_pre", 256'(m_axis_req_valid), 256'(1'b0));
        cyc();
        chk_out("p0", 7'h11);
        chk("p0_sel", 256'(m_axis_req_sel), 256'(2'b01));
        chk("p0_queue", 256'(m_axis_req_queue), 256'(13'h11));
        s_axis_req_valid = 2'b00;
        cyc();
        chk("p0_drop", 256'(m_axis_req_valid), 256'(1'b0));
        // single port 1 request
        s_axis_req_valid = 2'b10;
        #1 chk("p1_ready", 256'(s_axis_req_ready), 256'(2'b10));
        @(negedge clk);
        cyc();
        chk_out("p1", 7'h6A);
        chk("p1_sel", 256'(m_axis_req_sel), 256'(2'b10));
        chk("p1_queue", 256'(m_axis_req_queue), 256'(13'd5));
        s_axis_req_valid = 2'b00;
        cyc();
        chk("p1_drop", 256'(m_axis_req_valid), 256'(1'b0));
        // both valid, full throughput, alternating grants
        s_axis_req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk_out("rr", seq[i]);
        end
        // backpressure while both valid: output must hold port 1's request
        m_axis_req_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            acc += int'(|(s_axis_req_valid & s_axis_req_ready));
            cyc();
            chk_out("bp_hold", 7'h6A);
        end
        chk("bp_accepts", 256'(acc >= 1 && acc <= 2), 256'(1'b1));
        m_axis_req_ready = 1'b1;
        cyc();
        chk_out("bp_rel0", 7'h11);
        cyc();
        chk_out("bp_rel1", 7'h6A);
        s_axis_req_valid = 2'b00;
        cyc();
        chk("bp_drain", 256'(m_axis_req_valid), 256'(1'b0));
        // fill main and temp, then reset mid-transfer
        m_axis_req_ready = 1'b0;
        s_axis_req_valid = 2'b11;
        cyc();
        cyc();
        chk_out("fill", 7'h11);
        chk("fill_ready", 256'(s_axis_req_ready), 256'(2'b00));
        rst = 1'b0;
        #1 chk("mid_rst_valid", 256'(m_axis_req_valid), 256'(1'b0));
        chk("mid_rst_tag", 256'(m_axis_req_tag), 256'(7'h0));
        chk("mid_rst_ready", 256'(s_axis_req_ready), 256'(2'b00));
        @(negedge clk);
        rst = 1'b1;
        s_axis_req_valid = 2'b00;
        m_axis_req_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("post_rst_valid", 256'(m_axis_req_valid), 256'(1'b0));
        end
        // status demux vectors
        for (int i = 0; i < 4; i++) begin
            s_axis_req_status_tag = tbl[i].tag;
            s_axis_req_status_full = tbl[i].full;
            s_axis_req_status_error = tbl[i].err;
            s_axis_req_status_valid = tbl[i].vld;
`ifdef CPL_OP_MUX_STATUS_REG_EN
            cyc();
`else
            #1;
`endif
            chk("st_tag", 256'(m_axis_req_status_tag), 256'(tbl[i].e_tag));
            chk("st_full", 256'(m_axis_req_status_full), 256'(tbl[i].e_full));
            chk("st_err", 256'(m_axis_req_status_error), 256'(tbl[i].e_err));
            chk("st_valid", 256'(m_axis_req_status_valid), 256'(tbl[i].e_vld));
`ifndef CPL_OP_MUX_STATUS_REG_EN
            @(negedge clk);
`endif
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
